// File: rtl/auto_bright_ctrl.sv
// -----------------------------------------------------------------------------
// auto_bright_ctrl
//
// Frame-statistics controller for the linear brightness-adjust stage. It taps
// the raw pixel stream, computes the mean luma of every frame and, during
// vertical blanking, moves a signed brightness offset toward
// (target_luma - mean) by at most STEP_MAX per frame.
//
// Ports:
//   clk          pixel clock
//   reset        synchronous, active-high reset
//   enable       1 = closed-loop updates, 0 = force adjust_val to 0
//   target_luma  desired mean luma (unsigned 8 bit)
//   vs_in        vertical sync, rising edge marks a frame boundary
//   valid_i      pixel qualifier
//   img_data_i   pixel {R[23:16], G[15:8], B[7:0]}
//   adjust_val   signed offset, -255..+255
//   mean_luma    last computed frame mean
//   mean_valid   one-cycle pulse when mean_luma/adjust_val update
//   busy         high while the divider runs
// -----------------------------------------------------------------------------
module auto_bright_ctrl #(
    parameter int STEP_MAX = 8,
    parameter int DEADBAND = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  target_luma,
    input  logic        vs_in,
    input  logic        valid_i,
    input  logic [23:0] img_data_i,
    output logic [8:0]  adjust_val,
    output logic [7:0]  mean_luma,
    output logic        mean_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic signed [11:0] STEP_S = 12'(STEP_MAX);
    localparam logic signed [11:0] DB_S   = 12'(DEADBAND);
    localparam logic signed [11:0] LIM_S  = 12'sd255;

    // luma pipeline
    logic [15:0] luma_prod_s;
    logic [15:0] luma_sum_r;
    logic        y_valid1_r;
    logic [7:0]  y_r;
    logic        y_valid2_r;

    // sync delay line, kept in step with the luma pipeline
    logic        vs_d1_r;
    logic        vs_d2_r;
    logic        vs_d3_r;
    logic        frame_edge_s;

    // frame accumulators
    logic [31:0] acc_sum_r;
    logic [23:0] acc_cnt_r;

    // divider
    logic [31:0] div_quo_r;
    logic [23:0] div_rem_r;
    logic [23:0] div_den_r;
    logic [4:0]  bit_cnt_r;
    logic [24:0] div_trial_s;
    logic        div_fit_s;
    logic        div_start_s;
    logic [7:0]  quo_sat_s;

    // controller
    state_t             state_r;
    state_t             state_nxt_s;
    logic signed [11:0] desired_s;
    logic signed [11:0] diff_s;
    logic signed [11:0] step_s;
    logic signed [11:0] sum_s;
    logic [8:0]         adj_nxt_s;

    logic [8:0]  adjust_val_r;
    logic [7:0]  mean_luma_r;
    logic        mean_valid_r;
    logic        busy_r;

    assign adjust_val = adjust_val_r;
    assign mean_luma  = mean_luma_r;
    assign mean_valid = mean_valid_r;
    assign busy       = busy_r;

    // Weighted RGB sum; the largest value (256 * 255) still fits 16 bits.
    always_comb begin
        luma_prod_s = 16'd77  * {8'd0, img_data_i[23:16]}
                    + 16'd150 * {8'd0, img_data_i[15:8]}
                    + 16'd29  * {8'd0, img_data_i[7:0]};
    end

    // Two-stage luma pipeline with the pixel qualifier and sync riding along.
    always_ff @(posedge clk) begin
        if (reset) begin
            luma_sum_r <= 16'd0;
            y_valid1_r <= 1'b0;
            y_r        <= 8'd0;
            y_valid2_r <= 1'b0;
            vs_d1_r    <= 1'b0;
            vs_d2_r    <= 1'b0;
            vs_d3_r    <= 1'b0;
        end else begin
            luma_sum_r <= luma_prod_s;
            y_valid1_r <= valid_i;
            y_r        <= 8'(luma_sum_r >> 4'd8);
            y_valid2_r <= y_valid1_r;
            vs_d1_r    <= vs_in;
            vs_d2_r    <= vs_d1_r;
            vs_d3_r    <= vs_d2_r;
        end
    end

    assign frame_edge_s = vs_d2_r & ~vs_d3_r;
    // Only an idle controller accepts a finished frame; statistics of a frame
    // that ends while a divide is still in flight are dropped.
    assign div_start_s  = (state_r == ST_IDLE) && frame_edge_s && (acc_cnt_r != 24'd0);

    // Per-frame luma sum and pixel count; a pixel on the boundary opens the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_sum_r <= 32'd0;
            acc_cnt_r <= 24'd0;
        end else if (frame_edge_s) begin
            acc_sum_r <= y_valid2_r ? {24'd0, y_r} : 32'd0;
            acc_cnt_r <= y_valid2_r ? 24'd1 : 24'd0;
        end else if (y_valid2_r) begin
            acc_sum_r <= acc_sum_r + {24'd0, y_r};
            acc_cnt_r <= acc_cnt_r + 24'd1;
        end else begin
            acc_sum_r <= acc_sum_r;
            acc_cnt_r <= acc_cnt_r;
        end
    end

    // Restoring-divide trial: shift the next dividend bit into the remainder.
    always_comb begin
        div_trial_s = {div_rem_r, div_quo_r[31]};
        div_fit_s   = (div_trial_s >= {1'b0, div_den_r});
        if (div_quo_r[31:8] != 24'd0) begin
            quo_sat_s = 8'd255;
        end else begin
            quo_sat_s = div_quo_r[7:0];
        end
    end

    // Divider datapath: load on an accepted boundary, then one quotient bit per clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_quo_r <= 32'd0;
            div_rem_r <= 24'd0;
            div_den_r <= 24'd0;
            bit_cnt_r <= 5'd0;
        end else if (div_start_s) begin
            div_quo_r <= acc_sum_r;
            div_rem_r <= 24'd0;
            div_den_r <= acc_cnt_r;
            bit_cnt_r <= 5'd31;
        end else if (state_r == ST_DIV) begin
            if (div_fit_s) begin
                div_rem_r <= 24'(div_trial_s - {1'b0, div_den_r});
                div_quo_r <= {div_quo_r[30:0], 1'b1};
            end else begin
                div_rem_r <= div_trial_s[23:0];
                div_quo_r <= {div_quo_r[30:0], 1'b0};
            end
            bit_cnt_r <= bit_cnt_r - 5'd1;
        end else begin
            div_quo_r <= div_quo_r;
            div_rem_r <= div_rem_r;
            div_den_r <= div_den_r;
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Next-state logic for IDLE -> DIV -> UPDATE -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (div_start_s) begin
                    state_nxt_s = ST_DIV;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (bit_cnt_r == 5'd0) begin
                    state_nxt_s = ST_UPDATE;
                end else begin
                    state_nxt_s = ST_DIV;
                end
            end
            ST_UPDATE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Offset step: bounded move toward (target - mean) outside the deadband,
    // with the result kept inside the 9-bit signed range.
    always_comb begin
        desired_s = $signed({4'd0, target_luma}) - $signed({4'd0, quo_sat_s});
        diff_s    = desired_s - $signed({{3{adjust_val_r[8]}}, adjust_val_r});
        if ((diff_s > DB_S) || (diff_s < -DB_S)) begin
            if (diff_s > STEP_S) begin
                step_s = STEP_S;
            end else if (diff_s < -STEP_S) begin
                step_s = -STEP_S;
            end else begin
                step_s = diff_s;
            end
        end else begin
            step_s = 12'sd0;
        end
        sum_s = $signed({{3{adjust_val_r[8]}}, adjust_val_r}) + step_s;
        if (sum_s > LIM_S) begin
            adj_nxt_s = 9'h0FF;
        end else if (sum_s < -LIM_S) begin
            adj_nxt_s = 9'h101;
        end else begin
            adj_nxt_s = sum_s[8:0];
        end
    end

    // Registered outputs; enable low overrides any update and pins the offset at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            adjust_val_r <= 9'd0;
            mean_luma_r  <= 8'd0;
            mean_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            mean_valid_r <= (state_r == ST_UPDATE);
            busy_r       <= (state_nxt_s == ST_DIV);
            if (state_r == ST_UPDATE) begin
                mean_luma_r <= quo_sat_s;
            end else begin
                mean_luma_r <= mean_luma_r;
            end
            if (!enable) begin
                adjust_val_r <= 9'd0;
            end else if (state_r == ST_UPDATE) begin
                adjust_val_r <= adj_nxt_s;
            end else begin
                adjust_val_r <= adjust_val_r;
            end
        end
    end

endmodule

// File: doc/auto_bright_ctrl.md
Name: auto_bright_ctrl

Overview:
Frame-statistics controller that drives the signed brightness offset consumed by the linear brightness-adjust stage. It sits in parallel with that stage on the raw input stream and measures the mean luma of each frame. During vertical blanking it moves the offset toward (target − mean), by a bounded step per frame.

Parameters:
STEP_MAX, 8, maximum change of adjust_val per frame (1..255)
DEADBAND, 2, no update when |desired − adjust_val| <= DEADBAND
Y_PIPE, 2, luma pipeline depth in clk (fixed; vs is delayed by the same amount)

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
enable  input  1  1 = closed-loop updates; 0 = force adjust_val to 0
target_luma  input  8  desired mean luma, unsigned
vs_in  input  1  vertical sync, active-high; rising edge = frame boundary
valid_i  input  1  pixel qualifier
img_data_i  input  24  {R[23:16], G[15:8], B[7:0]}
adjust_val  output  9  signed two's-complement offset, −255..+255
mean_luma  output  8  last computed frame mean
mean_valid  output  1  one-cycle pulse when mean_luma/adjust_val update
busy  output  1  high while the divider runs

Behaviour:
- Reset is synchronous and active-high, on one clock clk. All registers clear on reset: adjust_val=0, mean_luma=0, mean_valid=0, busy=0, accumulators=0, FSM=IDLE. Reset mid-divide aborts the divide with no mean_valid.
- Luma: Y = (77R + 150G + 29B) >> 8. Products are summed in 16 bits; Y is 8-bit unsigned. The computation takes 2 register stages, and valid travels with Y.
- vs_in is delayed 2 clk (vs_d2). The edge detect runs on vs_d2, so pixels stay aligned with frame boundaries.
- Accumulators: sum is 32-bit and cnt is 24-bit. Each valid Y adds Y to sum and 1 to cnt.
- On a vs_d2 rising edge, sum and cnt are latched into the divider operands. In the same cycle, the accumulators restart: sum=0 and cnt=0, or sum=Y and cnt=1 if a valid Y coincides with the edge.
- FSM states are IDLE, DIV, UPDATE.
- IDLE → DIV on a vs_d2 edge with latched cnt≠0. If cnt=0, stay in IDLE: no mean_valid and no change to adjust_val.
- DIV: restoring divide of sum by cnt, 1 quotient bit per clk, 32 clk. busy=1 throughout. The quotient saturates to 255.
- DIV → UPDATE after bit 0 is resolved.
- UPDATE (1 clk):
  - desired = target_luma − quotient, as a signed 10-bit value.
  - d = desired − adjust_val.
  - If |d| <= DEADBAND, adjust_val is unchanged. Otherwise adjust_val += clamp(d, −STEP_MAX, +STEP_MAX).
  - The result is clamped to [−255, +255].
  - mean_luma = quotient. mean_valid is pulsed high for this one cycle with the registered outputs. Then → IDLE.
- Latency: if vs_in is first sampled high at cycle 0, mean_valid is high at cycle 36. The bench checks exactly 36.
- A vs_d2 edge while in DIV/UPDATE has two effects:
  - The accumulators restart normally.
  - The just-ended frame's statistics are discarded. The in-flight divide completes unaffected, and no second divide is queued.
- enable=0:
  - adjust_val is forced to 0 on the next clk and held there.
  - Statistics and the mean_luma/mean_valid outputs keep operating.
  - When enable returns to 1, updates resume from 0 at the next UPDATE.
- adjust_val changes only in UPDATE (or via enable/reset), so it changes only during blanking.

Test Plan:
- 4x4 frames of (100,100,100), target 128, defaults → mean_luma=100 each frame. adjust_val goes 8, 16, 24, 28, then holds 28 (remaining error 0 is within the deadband).
- Frames of (255,255,255), target 0 → mean 255. adjust_val steps −8 per frame, reaches −255 after 32 frames, and stays at −255 with no wrap.
- Single pixel (255,0,0) per frame → mean_luma=76 and mean_valid exactly 36 clk after the vs_in rise.
- Frame with zero valid pixels → no mean_valid pulse and adjust_val unchanged.
- adjust_val=24, drop enable → adjust_val=0 next clk. mean_valid pulses continue with correct means, and adjust_val stays 0.
- Assert reset 10 clk into DIV → all outputs 0 the next cycle and no mean_valid. The next frame computes normally.
